// File: rtl/note_tone_gen.sv
// ---------------------------------------------------------------------------
// note_tone_gen
//
// Converts a note index, an octave shift and a note-active gate into a
// square-wave buzzer drive. A base half-period table (computed for a
// 100 MHz clock) is scaled by the clamped octave shift, and a phase counter
// counts out each half period. Pitch changes and gate release take effect
// only on half-period boundaries, so the output never shows a short pulse.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   reset        in   asynchronous reset, active low (0 = reset)
//   note         in   [7:0] note index, 2..11 valid, anything else is silence
//   octave_shift in   [3:0] signed octave offset, clamped to OCT_MIN..OCT_MAX
//   note_active  in   tone requested while high
//   volume       in   [2:0] duty setting (only with NOTE_TONE_VOLUME_EN)
//   buzzer       out  square-wave drive
//   playing      out  high while the FSM is in PLAY
//   half_period  out  [CNT_W-1:0] half period in use, 0 when idle
//
// Optional feature macro: NOTE_TONE_VOLUME_EN
//   Adds the volume input and an 8-bit free-running carrier. During the high
//   phase the buzzer is gated by (carrier[7:5] <= volume), giving a duty of
//   (volume+1)/8 at clk/256. volume=7 reproduces the plain square wave.
// ---------------------------------------------------------------------------
module note_tone_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int OCT_MIN = -3,
    parameter int OCT_MAX = 3,
    parameter int CNT_W   = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       note,
    input  logic [3:0]       octave_shift,
    input  logic             note_active,
`ifdef NOTE_TONE_VOLUME_EN
    input  logic [2:0]       volume,
`endif
    output logic             buzzer,
    output logic             playing,
    output logic [CNT_W-1:0] half_period
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // The table below is fixed for a 100 MHz clock; CLK_HZ only documents
    // that assumption, so a differing value simply selects an empty block.
    if (CLK_HZ != 100_000_000) begin : g_clk_not_table_rate
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             tone_q, tone_d;

    logic signed [3:0] oct_in;
    logic signed [3:0] oct_clamped;
    logic [3:0]        shift_amt;
    logic [CNT_W-1:0]  base_half;
    logic [CNT_W-1:0]  target_half;
    logic              go;
    logic              boundary;

    // Base half-period table in clk cycles at 100 MHz.
    function automatic logic [CNT_W-1:0] note_base(input logic [7:0] n);
        logic [CNT_W-1:0] v;
        case (n)
            8'd2:    v = CNT_W'(191110);
            8'd3:    v = CNT_W'(170265);
            8'd4:    v = CNT_W'(151685);
            8'd5:    v = CNT_W'(143172);
            8'd6:    v = CNT_W'(127551);
            8'd7:    v = CNT_W'(113636);
            8'd8:    v = CNT_W'(101239);
            8'd9:    v = CNT_W'(95556);
            8'd10:   v = CNT_W'(85131);
            8'd11:   v = CNT_W'(75843);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Target pitch: clamp the octave, then shift the table entry right for
    // higher octaves and left for lower ones. Invalid notes give 0.
    always_comb begin
        oct_in      = $signed(octave_shift);
        oct_clamped = oct_in;
        if (int'(oct_in) < OCT_MIN) begin
            oct_clamped = 4'(OCT_MIN);
        end else if (int'(oct_in) > OCT_MAX) begin
            oct_clamped = 4'(OCT_MAX);
        end

        shift_amt = oct_clamped[3] ? 4'(-oct_clamped) : 4'(oct_clamped);
        base_half = note_base(note);

        if (oct_clamped[3]) begin
            target_half = base_half << shift_amt;
        end else begin
            target_half = base_half >> shift_amt;
        end
    end

    assign go       = note_active && (target_half != '0);
    assign boundary = (count_q == half_q - CNT_W'(1));

    // State register together with the datapath flops it steers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            half_q  <= '0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            half_q  <= half_d;
            tone_q  <= tone_d;
        end
    end

    // Next-state logic. In PLAY the counter runs freely; only at a boundary
    // is the gate re-examined and a new pitch latched, so every phase
    // completes at the length it started with.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        half_d  = half_q;
        tone_d  = tone_q;

        case (state_q)
            IDLE: begin
                tone_d  = 1'b0;
                count_d = '0;
                half_d  = '0;
                if (go) begin
                    half_d  = target_half;
                    tone_d  = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                count_d = count_q + CNT_W'(1);
                if (boundary) begin
                    count_d = '0;
                    if (go) begin
                        tone_d = ~tone_q;
                        half_d = target_half;
                    end else begin
                        tone_d  = 1'b0;
                        half_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                half_d  = '0;
                tone_d  = 1'b0;
            end
        endcase
    end

`ifdef NOTE_TONE_VOLUME_EN
    logic [7:0] carrier_q, carrier_d;

    // Free-running carrier used to chop the high phase for volume control.
    always_comb begin
        carrier_d = carrier_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carrier_q <= '0;
        end else begin
            carrier_q <= carrier_d;
        end
    end

    // Output logic with the high phase gated by the carrier.
    always_comb begin
        playing     = (state_q == PLAY);
        half_period = half_q;
        buzzer      = tone_q && (carrier_q[7:5] <= volume);
    end
`else
    // Output logic: plain square wave.
    always_comb begin
        playing     = (state_q == PLAY);
        half_period = half_q;
        buzzer      = tone_q;
    end
`endif

endmodule

// File: tb/tb_note_tone_gen.sv
// ---------------------------------------------------------------------------
// tb_note_tone_gen
//
// Directed self-checking bench for note_tone_gen. Inputs change on the
// falling clock edge and outputs are sampled on the falling edge, half a
// cycle away from the active rising edge. Octave +3 is used for the timing
// tests so that whole half periods stay short.
// ---------------------------------------------------------------------------
module tb_note_tone_gen;

    localparam int CNT_W = 22;

    logic             clk;
    logic             reset;
    logic [7:0]       note;
    logic [3:0]       octaveShift;
    logic             noteActive;
`ifdef NOTE_TONE_VOLUME_EN
    logic [2:0]       volume;
`endif
    logic             buzzer;
    logic             playing;
    logic [CNT_W-1:0] halfPeriod;

    int testCount;
    int failCount;
    int measured;
    int partial;

    note_tone_gen #(
        .CLK_HZ (100_000_000),
        .OCT_MIN(-3),
        .OCT_MAX(3),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .note        (note),
        .octave_shift(octaveShift),
        .note_active (noteActive),
`ifdef NOTE_TONE_VOLUME_EN
        .volume      (volume),
`endif
        .buzzer      (buzzer),
        .playing     (playing),
        .half_period (halfPeriod)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive the note inputs.
    task automatic applyStimulus(input logic [7:0] n, input logic [3:0] oct,
                                 input logic gate);
        note        = n;
        octaveShift = oct;
        noteActive  = gate;
    endtask

    // Reset, set up the inputs, release, and return at the falling edge
    // just after the first rising edge out of reset.
    task automatic startTone(input logic [7:0] n, input logic [3:0] oct);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(n, oct, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Count falling edges until buzzer changes, bounded by maxCycles.
    task automatic waitToggle(input int maxCycles, output int cycles);
        logic startLevel;
        startLevel = buzzer;
        cycles     = 0;
        while (cycles < maxCycles) begin
            @(negedge clk);
            cycles++;
            if (buzzer !== startLevel) break;
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
`ifdef NOTE_TONE_VOLUME_EN
        volume = 3'd7;
`endif
        reset = 1'b0;
        applyStimulus(8'd7, 4'd0, 1'b1);

        // Reset held with a valid note requested.
        repeat (3) @(negedge clk);
        checkOutput("reset_buzzer", 32'(buzzer), 32'd0);
        checkOutput("reset_playing", 32'(playing), 32'd0);
        checkOutput("reset_half", 32'(halfPeriod), 32'd0);

        // First edge after release starts A4.
        reset = 1'b1;
        @(negedge clk);
        checkOutput("a4_buzzer", 32'(buzzer), 32'd1);
        checkOutput("a4_playing", 32'(playing), 32'd1);
        checkOutput("a4_half", 32'(halfPeriod), 32'd113636);

        // Octave scaling and clamping.
        startTone(8'd2, 4'd1);
        checkOutput("c4_oct_p1", 32'(halfPeriod), 32'd95555);
        startTone(8'd2, 4'b1101);
        checkOutput("c4_oct_m3", 32'(halfPeriod), 32'd1528880);
        startTone(8'd2, 4'b0111);
        checkOutput("c4_oct_clamp_hi", 32'(halfPeriod), 32'd23888);
        startTone(8'd2, 4'b1000);
        checkOutput("c4_oct_clamp_lo", 32'(halfPeriod), 32'd1528880);

        // Boundary pickup: A4+3 then switch to C5+3 mid high phase.
        startTone(8'd7, 4'd3);
        checkOutput("a4p3_half", 32'(halfPeriod), 32'd14204);
        repeat (100) @(negedge clk);
        note = 8'd9;
        waitToggle(20000, partial);
        checkOutput("a4p3_high_len", 32'(100 + partial), 32'd14204);
        checkOutput("a4p3_low_level", 32'(buzzer), 32'd0);
        checkOutput("c5p3_half", 32'(halfPeriod), 32'd11944);
        waitToggle(20000, measured);
        checkOutput("c5p3_low_len", 32'(measured), 32'd11944);

        // Gate release 10 cycles into a high phase of E5+3.
        startTone(8'd11, 4'd3);
        checkOutput("e5p3_half", 32'(halfPeriod), 32'd9480);
        repeat (10) @(negedge clk);
        noteActive = 1'b0;
        waitToggle(20000, partial);
        checkOutput("release_high_len", 32'(10 + partial), 32'd9480);
        checkOutput("release_playing", 32'(playing), 32'd0);
        checkOutput("release_half", 32'(halfPeriod), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("release_idle_buzzer", 32'(buzzer), 32'd0);

        // Invalid notes from IDLE stay silent.
        startTone(8'd0, 4'd0);
        repeat (20) @(negedge clk);
        checkOutput("note0_buzzer", 32'(buzzer), 32'd0);
        checkOutput("note0_playing", 32'(playing), 32'd0);
        startTone(8'd12, 4'd0);
        repeat (20) @(negedge clk);
        checkOutput("note12_buzzer", 32'(buzzer), 32'd0);
        checkOutput("note12_half", 32'(halfPeriod), 32'd0);

        // Note goes invalid during PLAY: stops at the next boundary.
        startTone(8'd11, 4'd3);
        repeat (50) @(negedge clk);
        note = 8'd0;
        checkOutput("invalid_mid_playing", 32'(playing), 32'd1);
        waitToggle(20000, partial);
        checkOutput("invalid_high_len", 32'(50 + partial), 32'd9480);
        checkOutput("invalid_stop_playing", 32'(playing), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream audio stage: turns the received note index, octave shift and note-active gate into a square-wave buzzer drive.
- Sits between the note-duration/octave control logic and the buzzer pin.
- Uses a half-period lookup table, octave scaling by shifting, and a free-running phase counter.
- Pitch changes take effect only on half-period boundaries, so the output is glitch-free.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency. Documentation only; the table is computed for 100 MHz.
- OCT_MIN, -3: lowest octave shift accepted; lower inputs saturate to this value.
- OCT_MAX, 3: highest octave shift accepted; higher inputs saturate to this value.
- CNT_W, 22: width of the half-period counter and the half-period register.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- note  input  8  note index; 2..11 valid, anything else is silence.
- octave_shift  input  4  signed two's-complement octave offset.
- note_active  input  1  gate; tone is requested while high.
- buzzer  output  1  square-wave drive.
- playing  output  1  high while the state machine is in PLAY.
- half_period  output  CNT_W  half period currently in use, in clk cycles; 0 when idle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, buzzer=0, playing=0, half_period=0, phase counter=0. Release is sampled synchronously.
- Base table, half-period counts at 100 MHz, index to note:
  - 2 = C4 191110, 3 = D4 170265, 4 = E4 151685, 5 = F4 143172, 6 = G4 127551
  - 7 = A4 113636, 8 = B4 101239, 9 = C5 95556, 10 = D5 85131, 11 = E5 75843
- Octave scaling:
  - First clamp octave_shift to [OCT_MIN, OCT_MAX].
  - k > 0: half = base >> k. k < 0: half = base << |k|. k = 0: half = base.
  - Maximum value is 191110<<3 = 1528880, which fits in 22 bits. No overflow is possible.
- Combinational target: target_half = scaled value when note is 2..11, else 0.
- go condition: note_active=1 and target_half != 0.
- FSM, IDLE:
  - buzzer=0.
  - On go at a clock edge: half_period<=target_half, count<=0, buzzer<=1, state<=PLAY.
  - Latency: buzzer is high on the first edge where go is true (1 cycle).
- FSM, PLAY:
  - count increments every cycle.
  - When count==half_period-1 (boundary): count<=0, then check go.
  - If go: buzzer toggles and half_period<=target_half, so a new note or octave is picked up here.
  - If not go: buzzer<=0, half_period<=0, state<=IDLE.
  - Tail after the gate falls is at most one half period.
- Mid-period rules:
  - Changes to note or octave_shift are ignored until the next boundary.
  - note_active falling mid-period does not cut the current phase.
  - note_active pulses shorter than one half period that start in IDLE still produce one full high half-period.
- playing=1 exactly while state=PLAY.
- Only reset can abort a half-period early.

Optional Feature:
- Macro: NOTE_TONE_VOLUME_EN.
- When defined:
  - Adds input port volume [2:0].
  - Adds an 8-bit free-running carrier counter.
  - During the high phase, buzzer = tone_high AND (carrier[7:5] <= volume), giving duty (volume+1)/8 at a 390.625 kHz carrier.
  - volume=7 gives an output identical to the non-feature build.
  - Low phase and IDLE stay 0.
- When undefined: no volume port, no carrier; buzzer is the plain square wave.

Test Plan:
- Reset hold: reset=0 with note=7, note_active=1 -> buzzer=0, playing=0, half_period=0. After release, first edge gives buzzer=1, half_period=113636, and the toggle period is 227272 cycles (440 Hz).
- Octave shift: note=2 with octave_shift=+1 -> half_period=95555. With octave_shift=-3 -> 1528880. With octave_shift=4'b0111 -> clamped to +3, 23888. With 4'b1000 -> clamped to -3.
- Boundary pickup: playing note=7, switch note=9 mid-phase -> current phase stays 113636 cycles, and the next phase is 95556 cycles. No short pulse appears.
- Gate release: drop note_active 10 cycles into a high phase of note=11 -> buzzer stays high until cycle 75843, then goes 0 and state returns to IDLE with playing=0.
- Invalid note: note=0 or note=12 with note_active=1 in IDLE -> buzzer stays 0. If the note goes invalid during PLAY, the block stops at the next boundary.
- NOTE_TONE_VOLUME_EN: volume=3, note=7 -> during high phases buzzer is high 128 of every 256 cycles. volume=7 matches the plain build cycle for cycle.
